// File: rtl/binary_div_8_seq_bi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : binary_div_pkg                                                   |
// | Purpose : shared widths, FSM state encodings and magnitude/negate helpers  |
// |           for the sequential signed restoring divider.                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package binary_div_pkg;

  // Default operand width; the dividend is 2*DIV_W-1 bits wide.
  localparam int DIV_W = 8;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Two's-complement negate at 32 bits; callers slice the low bits they need.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return -x;
  endfunction

  // Magnitude of a sign-extended value. The result is read back as unsigned,
  // so the most-negative input maps to its true magnitude without wrapping.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/binary_div_8_seq_bi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : binary_div_8_seq_bi_if                                         |
// | Purpose   : request/result bundle of the sequential signed divider.        |
// | Ports     : en, start, dividend[2W-2:0], divisor[W-1:0]  (master -> slave) |
// |             busy, done, quot[W-1:0], rem[W-1:0], ovf, dz (slave -> master) |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface binary_div_8_seq_bi_if
  import binary_div_pkg::*;
#(
  parameter int W = DIV_W
);
  logic           en;
  logic           start;
  logic [2*W-2:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic           ovf;
  logic           dz;

  modport master (
    output en, start, dividend, divisor,
    input  busy, done, quot, rem, ovf, dz
  );

  modport slave (
    input  en, start, dividend, divisor,
    output busy, done, quot, rem, ovf, dz
  );
endinterface
`default_nettype wire

// File: rtl/binary_div_8_seq_bi_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : binary_div_step                                                  |
// | Purpose : one restoring shift-compare-subtract iteration (combinational).  |
// | Ports   : pr[W:0] partial remainder, nbit next dividend bit,               |
// |           dmag[W-1:0] divisor magnitude -> pr_next[W:0], qbit              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module binary_div_step
  import binary_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   pr,
  input  logic         nbit,
  input  logic [W-1:0] dmag,
  output logic [W:0]   pr_next,
  output logic         qbit
);

  logic [W+1:0] w_sh;

  assign w_sh = {pr, nbit};

  // The compare uses the full shifted value; the subtract result always fits
  // W+1 bits because pr stays below dmag between iterations.
  assign qbit    = (w_sh >= {2'b00, dmag});
  assign pr_next = qbit ? (w_sh[W:0] - {1'b0, dmag}) : w_sh[W:0];

endmodule
`default_nettype wire

// File: rtl/binary_div_8_seq_bi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : binary_div_8_seq_bi                                              |
// | Purpose : sequential signed divider, (2W-1)-bit dividend by W-bit divisor, |
// |           restoring on magnitudes, one quotient bit per enabled cycle.     |
// |           Quotient truncates toward zero and saturates with ovf; the       |
// |           remainder takes the dividend's sign; dz flags a zero divisor.    |
// | Ports   : clk, rst_n (async, active-low), bus (slave modport of           |
// |           binary_div_8_seq_bi_if)                                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module binary_div_8_seq_bi
  import binary_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  binary_div_8_seq_bi_if.slave  bus
);

  localparam int DVW = 2*W - 1;
  localparam int CW  = $clog2(DVW + 1);

  localparam logic [DVW-1:0] c_QPOS_MAX = DVW'((1 << (W-1)) - 1);
  localparam logic [DVW-1:0] c_QNEG_MAX = DVW'(1 << (W-1));

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [DVW-1:0] r_dvd;     // dividend magnitude, shifted out MSB first
  logic [DVW-1:0] r_q;       // quotient magnitude, shifted in LSB
  logic [W:0]     r_pr;      // partial remainder
  logic [W-1:0]   r_dmag;
  logic           r_sdvd;
  logic           r_sdsr;
  logic           r_dz_lat;

  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_quot;
  logic [W-1:0]   r_rem;
  logic           r_ovf;
  logic           r_dz;

  logic [W:0]     w_pr_next;
  logic           w_qbit;
  logic           w_qneg;
  logic           w_ovf;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;

  binary_div_step #(.W(W)) u_step (
    .pr      (r_pr),
    .nbit    (r_dvd[DVW-1]),
    .dmag    (r_dmag),
    .pr_next (w_pr_next),
    .qbit    (w_qbit)
  );

  // Sign application and saturation, consumed in the FIX state.
  assign w_qneg = r_sdvd ^ r_sdsr;
  assign w_ovf  = !r_dz_lat && (w_qneg ? (r_q > c_QNEG_MAX) : (r_q > c_QPOS_MAX));

  always_comb begin
    w_quot = '0;
    if (r_dz_lat) begin
      w_quot = '0;
    end else if (w_ovf) begin
      w_quot = w_qneg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      w_quot = w_qneg ? W'(neg32(32'(r_q))) : r_q[W-1:0];
    end
  end

  always_comb begin
    w_rem = '0;
    if (!r_dz_lat) begin
      w_rem = r_sdvd ? W'(neg32(32'(r_pr))) : r_pr[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_q      <= '0;
      r_pr     <= '0;
      r_dmag   <= '0;
      r_sdvd   <= 1'b0;
      r_sdsr   <= 1'b0;
      r_dz_lat <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_dvd    <= DVW'(abs32(32'(signed'(bus.dividend))));
            r_dmag   <= W'(abs32(32'(signed'(bus.divisor))));
            r_sdvd   <= bus.dividend[DVW-1];
            r_sdsr   <= bus.divisor[W-1];
            r_dz_lat <= (bus.divisor == '0);
            r_pr     <= '0;
            r_q      <= '0;
            r_cnt    <= CW'(DVW);
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_pr  <= w_pr_next;
          r_dvd <= {r_dvd[DVW-2:0], 1'b0};
          r_q   <= {r_q[DVW-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quot  <= w_quot;
          r_rem   <= w_rem;
          r_ovf   <= w_ovf;
          r_dz    <= r_dz_lat;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.quot = r_quot;
  assign bus.rem  = r_rem;
  assign bus.ovf  = r_ovf;
  assign bus.dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_binary_div_8_seq_bi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_binary_div_8_seq_bi                                           |
// | Purpose : directed self-checking bench for binary_div_8_seq_bi.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_binary_div_8_seq_bi;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  binary_div_8_seq_bi_if #(.W(8)) bus ();

  binary_div_8_seq_bi #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int q, input int r, input int o, input int d);
    check({tag, ".quot"}, int'($signed(bus.quot)), q);
    check({tag, ".rem"},  int'($signed(bus.rem)),  r);
    check({tag, ".ovf"},  int'(bus.ovf), o);
    check({tag, ".dz"},   int'(bus.dz),  d);
  endtask

  // Launch one division; returns clock edges from the start edge to done and
  // the number of samples with busy high. Optional en stall and extra start pulse.
  task automatic do_op(input string tag, input int a, input int b,
                       input int stall_at, input int stall_len, input int pulse_at,
                       output int lat, output int bcnt);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 15'(a);
    bus.divisor  = 8'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = 0;
    bcnt = int'(bus.busy);
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) bcnt++;
      if (lat == stall_at) bus.en = 1'b0;
      if (lat == stall_at + stall_len) bus.en = 1'b1;
      if (lat == pulse_at) begin
        bus.start    = 1'b1;
        bus.dividend = 15'(1000);
        bus.divisor  = 8'(3);
      end
      if (lat == pulse_at + 1) bus.start = 1'b0;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    check({tag, ".done"}, int'(bus.done), 1);
  endtask

  initial begin
    int lat;
    int bcnt;
    int ra[5];
    int rb[5];

    n_total = 0;
    n_pass  = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);

    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    check_res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Basic positive division with latency and busy length.
    do_op("p391", 391, 17, -1, 0, -1, lat, bcnt);
    check("p391.lat", lat, 16);
    check("p391.busy", bcnt, 16);
    check_res("p391", 23, 0, 0, 0);
    @(posedge clk); #1;
    check("p391.doneclr", int'(bus.done), 0);

    // Sign combinations.
    do_op("nm100", -100, 7, -1, 0, -1, lat, bcnt);
    check_res("nm100", -14, -2, 0, 0);
    do_op("p100n7", 100, -7, -1, 0, -1, lat, bcnt);
    check_res("p100n7", -14, 2, 0, 0);
    do_op("nn", -100, -7, -1, 0, -1, lat, bcnt);
    check_res("nn", 14, -2, 0, 0);

    // Overflow and saturation.
    do_op("ov1", 16383, 1, -1, 0, -1, lat, bcnt);
    check_res("ov1", 127, 0, 1, 0);
    do_op("ov2", -16384, 1, -1, 0, -1, lat, bcnt);
    check_res("ov2", -128, 0, 1, 0);
    do_op("ov3", -16384, -128, -1, 0, -1, lat, bcnt);
    check_res("ov3", 127, 0, 1, 0);
    do_op("edge", -16256, -128, -1, 0, -1, lat, bcnt);
    check_res("edge", 127, 0, 0, 0);
    do_op("n128n1", -128, -1, -1, 0, -1, lat, bcnt);
    check_res("n128n1", 127, 0, 1, 0);
    do_op("p128n1", 128, -1, -1, 0, -1, lat, bcnt);
    check_res("p128n1", -128, 0, 0, 0);

    // Divide by zero, then a normal op clears dz.
    do_op("dz", 55, 0, -1, 0, -1, lat, bcnt);
    check("dz.lat", lat, 16);
    check_res("dz", 0, 0, 0, 1);
    do_op("d20", 20, 3, -1, 0, -1, lat, bcnt);
    check_res("d20", 6, 2, 0, 0);

    // Start while busy is ignored.
    do_op("pulse", 391, 17, -1, 0, 5, lat, bcnt);
    check("pulse.lat", lat, 16);
    check_res("pulse", 23, 0, 0, 0);
    @(posedge clk); #1;
    check("pulse.idle", int'(bus.busy), 0);

    // Enable stall of 5 cycles stretches latency to 21.
    do_op("stall", 20, 3, 5, 5, -1, lat, bcnt);
    check("stall.lat", lat, 21);
    check_res("stall", 6, 2, 0, 0);

    // Asynchronous reset mid-calculation clears outputs immediately.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 15'(391);
    bus.divisor  = 8'(17);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy", int'(bus.busy), 0);
    check("arst.done", int'(bus.done), 0);
    check_res("arst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round trip against products of the 8x8 signed multiplier.
    ra = '{37, -128, 127, -1, -77};
    rb = '{-5, 127, 127, -128, 3};
    for (int i = 0; i < 5; i++) begin
      do_op("rt", ra[i] * rb[i], rb[i], -1, 0, -1, lat, bcnt);
      check_res($sformatf("rt%0d", i), ra[i], 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
